// File: rtl/axis_to_video.sv
// AXI4-Stream to parallel video raster with self-generated timing.
// The stream is locked to the raster on the start-of-frame marker.
module axis_to_video #(
  parameter int   DATA_BITS = 8,
  parameter int   H_ACTIVE  = 960,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 32,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 544,
  parameter int   V_FP      = 3,
  parameter int   V_SYNC    = 5,
  parameter int   V_BP      = 10,
  parameter logic SYNC_POL  = 1'b1
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic                 vid_hsync,
  output logic                 vid_vsync,
  output logic                 vid_active_video,
  output logic [DATA_BITS-1:0] vid_data,
  output logic                 locked,
  output logic                 underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_EOL  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_HS0  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_HS1  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_VS0  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_VS1  = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_SEEK,
    ST_WAIT,
    ST_RUN
  } state_t;

  state_t               r_state;
  logic [HW-1:0]        r_h_cnt;
  logic [VW-1:0]        r_v_cnt;
  logic                 r_hsync;
  logic                 r_vsync;
  logic                 r_active;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_locked;
  logic                 r_underflow;

  logic w_h_wrap;
  logic w_v_wrap;
  logic w_active;
  logic w_hs;
  logic w_vs;
  logic w_sof_pos;
  logic w_eol_pos;
  logic w_run;
  logic w_err;
  logic w_beat;
  logic w_take;
  logic w_fault;
  logic w_miss;
  logic w_tready;

  assign w_h_wrap  = (r_h_cnt == H_LAST);
  assign w_v_wrap  = (r_v_cnt == V_LAST);
  assign w_active  = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs      = (r_h_cnt >= H_HS0) && (r_h_cnt < H_HS1);
  assign w_vs      = (r_v_cnt >= V_VS0) && (r_v_cnt < V_VS1);
  assign w_sof_pos = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_eol_pos = (r_h_cnt == H_EOL);

  // A beat is misaligned if its markers disagree with the raster position
  assign w_err   = (s_axis_tuser != w_sof_pos) ||
                   (s_axis_tlast != w_eol_pos);
  assign w_run   = (r_state == ST_RUN);
  assign w_beat  = w_run && w_active && s_axis_tvalid;
  assign w_take  = w_beat && !w_err;
  assign w_fault = w_beat && w_err;
  assign w_miss  = w_run && w_active && !s_axis_tvalid;

  always_comb begin
    w_tready = 1'b0;
    unique case (r_state)
      ST_SEEK: w_tready = !(s_axis_tvalid && s_axis_tuser);
      ST_WAIT: w_tready = 1'b0;
      ST_RUN:  w_tready = w_active && !(s_axis_tvalid && w_err);
      default: w_tready = 1'b0;
    endcase
  end

  assign s_axis_tready = w_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state     <= ST_SEEK;
      r_hsync     <= ~SYNC_POL;
      r_vsync     <= ~SYNC_POL;
      r_active    <= 1'b0;
      r_data      <= '0;
      r_locked    <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_hsync     <= w_hs ? SYNC_POL : ~SYNC_POL;
      r_vsync     <= w_vs ? SYNC_POL : ~SYNC_POL;
      r_active    <= w_active;
      r_data      <= w_take ? s_axis_tdata : '0;
      r_locked    <= w_run;
      r_underflow <= w_miss;
      unique case (r_state)
        ST_SEEK:
          if (s_axis_tvalid && s_axis_tuser)
            r_state <= ST_WAIT;
        ST_WAIT:
          if (w_h_wrap && w_v_wrap)
            r_state <= ST_RUN;
        ST_RUN:
          if (w_fault)
            r_state <= ST_SEEK;
        default:
          r_state <= ST_SEEK;
      endcase
    end
  end

  assign vid_hsync        = r_hsync;
  assign vid_vsync        = r_vsync;
  assign vid_active_video = r_active;
  assign vid_data         = r_data;
  assign locked           = r_locked;
  assign underflow        = r_underflow;

endmodule

// File: tb/tb_axis_to_video.sv
// Directed bench for axis_to_video on a 14x7 raster.
// Each task drives one scenario and checks the raster cycle by cycle.
module tb_axis_to_video;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic [7:0] s_axis_tdata = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tuser = 1'b0;
  logic       vid_hsync;
  logic       vid_vsync;
  logic       vid_active_video;
  logic [7:0] vid_data;
  logic       locked;
  logic       underflow;

  int checks = 0;
  int failures = 0;
  int cyc;
  int p, h, v;
  bit act;
  bit acc;

  int         pix;
  int         junk;
  logic [7:0] base;
  bit         src_on;
  bit         drop_pend;
  bit         bad_pend;

  axis_to_video #(
    .DATA_BITS(8),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .vid_hsync(vid_hsync),
    .vid_vsync(vid_vsync),
    .vid_active_video(vid_active_video),
    .vid_data(vid_data),
    .locked(locked),
    .underflow(underflow)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk or posedge areset)
    if (areset) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic src_reset();
    pix = 0;
    junk = 0;
    base = 8'h00;
    src_on = 0;
    drop_pend = 0;
    bad_pend = 0;
    s_axis_tvalid = 1'b0;
    s_axis_tuser = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = 8'h00;
  endtask

  // Drive one beat, record the handshake, then observe after the edge.
  // p/h/v name the raster position whose outputs are now visible.
  task automatic tick();
    bit dropv;
    bit badl;
    dropv = drop_pend && junk == 0 && pix == 5;
    badl = bad_pend && junk == 0 && pix == 3;
    if (!src_on) begin
      s_axis_tvalid = 1'b0;
      s_axis_tuser = 1'b0;
      s_axis_tlast = 1'b0;
      s_axis_tdata = 8'h00;
    end else if (junk > 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tuser = 1'b0;
      s_axis_tlast = 1'b0;
      s_axis_tdata = 8'(8'hA0 + junk);
    end else begin
      s_axis_tvalid = !dropv;
      s_axis_tuser = (pix == 0);
      s_axis_tlast = (pix % 8 == 7) || badl;
      s_axis_tdata = 8'(base + pix);
    end
    #4;
    acc = s_axis_tvalid && s_axis_tready;
    @(negedge aclk);
    if (dropv) drop_pend = 0;
    if (badl) bad_pend = 0;
    if (acc) begin
      if (junk > 0) junk--;
      else pix = (pix + 1) % 32;
    end
    p = cyc - 1;
    h = p % 14;
    v = (p / 14) % 7;
    act = (h < 8) && (v < 4);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    src_reset();
    repeat (2) @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    src_reset();
    repeat (2) @(negedge aclk);
    checks++;
    if (vid_hsync !== 1'b0 || vid_vsync !== 1'b0) begin
      failures++;
      $display("FAIL rst_sync got=%b%b exp=00", vid_hsync, vid_vsync);
    end
    checks++;
    if (vid_active_video !== 1'b0 || vid_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_video got=%b/%h exp=0/00", vid_active_video, vid_data);
    end
    checks++;
    if (locked !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL rst_flags got=%b%b exp=00", locked, underflow);
    end
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL rst_tready_idle got=%b exp=1", s_axis_tready);
    end
    s_axis_tvalid = 1'b1;
    s_axis_tuser = 1'b1;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0) begin
      failures++;
      $display("FAIL rst_tready_sof got=%b exp=0", s_axis_tready);
    end
    src_reset();
  endtask

  task automatic test_raster();
    int nhs, nvs, nact;
    bit ehs, evs;
    nhs = 0;
    nvs = 0;
    nact = 0;
    do_reset();
    for (int i = 0; i < 196; i++) begin
      tick();
      ehs = (h >= 10) && (h < 12);
      evs = (v == 5);
      nhs += int'(vid_hsync);
      nvs += int'(vid_vsync);
      nact += int'(vid_active_video);
      checks++;
      if (vid_hsync !== ehs || vid_vsync !== evs) begin
        failures++;
        $display("FAIL raster_sync p=%0d got=%b%b exp=%b%b", p, vid_hsync, vid_vsync, ehs, evs);
      end
      checks++;
      if (vid_active_video !== act) begin
        failures++;
        $display("FAIL raster_active p=%0d got=%b exp=%b", p, vid_active_video, act);
      end
      checks++;
      if (vid_data !== 8'h00 || locked !== 1'b0 || underflow !== 1'b0) begin
        failures++;
        $display("FAIL raster_idle p=%0d got=%h/%b/%b exp=00/0/0", p, vid_data, locked, underflow);
      end
    end
    checks++;
    if (nhs != 28 || nvs != 28 || nact != 64) begin
      failures++;
      $display("FAIL raster_counts got=%0d/%0d/%0d exp=28/28/64", nhs, nvs, nact);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ed;
    do_reset();
    src_on = 1;
    for (int i = 0; i < 392; i++) begin
      tick();
      ed = (p >= 98 && act) ? 8'(v * 8 + h) : 8'h00;
      checks++;
      if (vid_data !== ed) begin
        failures++;
        $display("FAIL b2b_data p=%0d got=%h exp=%h", p, vid_data, ed);
      end
      checks++;
      if (locked !== (p >= 98)) begin
        failures++;
        $display("FAIL b2b_locked p=%0d got=%b exp=%b", p, locked, p >= 98);
      end
      checks++;
      if (underflow !== 1'b0) begin
        failures++;
        $display("FAIL b2b_underflow p=%0d got=%b exp=0", p, underflow);
      end
    end
  endtask

  task automatic test_junk();
    logic [7:0] ed;
    do_reset();
    src_on = 1;
    base = 8'h40;
    junk = 3;
    for (int i = 0; i < 196; i++) begin
      tick();
      if (p < 4) begin
        checks++;
        if (acc !== (p < 3)) begin
          failures++;
          $display("FAIL junk_accept p=%0d got=%b exp=%b", p, acc, p < 3);
        end
      end
      ed = (p >= 98 && act) ? 8'(8'h40 + v * 8 + h) : 8'h00;
      checks++;
      if (vid_data !== ed) begin
        failures++;
        $display("FAIL junk_data p=%0d got=%h exp=%h", p, vid_data, ed);
      end
      checks++;
      if (locked !== (p >= 98)) begin
        failures++;
        $display("FAIL junk_locked p=%0d got=%b exp=%b", p, locked, p >= 98);
      end
    end
  endtask

  task automatic test_underflow();
    logic [7:0] ed;
    bit el;
    int nuf;
    nuf = 0;
    do_reset();
    src_on = 1;
    base = 8'h40;
    drop_pend = 1;
    for (int i = 0; i < 294; i++) begin
      tick();
      nuf += int'(underflow);
      if (p >= 98 && p <= 102) ed = 8'(8'h40 + h);
      else if (p == 104) ed = 8'h45;
      else if (p >= 196 && act) ed = 8'(8'h40 + v * 8 + h);
      else ed = 8'h00;
      el = (p >= 98 && p <= 105) || (p >= 196);
      checks++;
      if (vid_data !== ed) begin
        failures++;
        $display("FAIL uf_data p=%0d got=%h exp=%h", p, vid_data, ed);
      end
      checks++;
      if (locked !== el) begin
        failures++;
        $display("FAIL uf_locked p=%0d got=%b exp=%b", p, locked, el);
      end
      checks++;
      if (underflow !== (p == 103)) begin
        failures++;
        $display("FAIL uf_pulse p=%0d got=%b exp=%b", p, underflow, p == 103);
      end
    end
    checks++;
    if (nuf != 1) begin
      failures++;
      $display("FAIL uf_count got=%0d exp=1", nuf);
    end
  endtask

  task automatic test_tlast();
    logic [7:0] ed;
    bit el;
    do_reset();
    src_on = 1;
    base = 8'h40;
    bad_pend = 1;
    for (int i = 0; i < 294; i++) begin
      tick();
      if (p == 101) begin
        checks++;
        if (acc !== 1'b0) begin
          failures++;
          $display("FAIL tlast_accept p=%0d got=%b exp=0", p, acc);
        end
      end
      if (p >= 98 && p <= 100) ed = 8'(8'h40 + h);
      else if (p >= 196 && act) ed = 8'(8'h40 + v * 8 + h);
      else ed = 8'h00;
      el = (p >= 98 && p <= 101) || (p >= 196);
      checks++;
      if (vid_data !== ed) begin
        failures++;
        $display("FAIL tlast_data p=%0d got=%h exp=%h", p, vid_data, ed);
      end
      checks++;
      if (locked !== el) begin
        failures++;
        $display("FAIL tlast_locked p=%0d got=%b exp=%b", p, locked, el);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] ed;
    do_reset();
    src_on = 1;
    base = 8'h40;
    for (int i = 0; i < 130; i++) tick();
    checks++;
    if (p != 129 || locked !== 1'b1 || vid_data !== 8'h53) begin
      failures++;
      $display("FAIL mid_prelock p=%0d got=%b/%h exp=1/53", p, locked, vid_data);
    end
    #2;
    areset = 1'b1;
    #1;
    checks++;
    if (vid_active_video !== 1'b0 || vid_data !== 8'h00) begin
      failures++;
      $display("FAIL mid_rst_video got=%b/%h exp=0/00", vid_active_video, vid_data);
    end
    checks++;
    if (locked !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_flags got=%b%b exp=00", locked, underflow);
    end
    checks++;
    if (vid_hsync !== 1'b0 || vid_vsync !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_sync got=%b%b exp=00", vid_hsync, vid_vsync);
    end
    src_reset();
    src_on = 1;
    base = 8'h40;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    for (int i = 0; i < 110; i++) begin
      tick();
      ed = (p >= 98 && act) ? 8'(8'h40 + v * 8 + h) : 8'h00;
      checks++;
      if (vid_active_video !== act) begin
        failures++;
        $display("FAIL mid_restart p=%0d got=%b exp=%b", p, vid_active_video, act);
      end
      checks++;
      if (locked !== (p >= 98)) begin
        failures++;
        $display("FAIL mid_relock p=%0d got=%b exp=%b", p, locked, p >= 98);
      end
      checks++;
      if (vid_data !== ed) begin
        failures++;
        $display("FAIL mid_data p=%0d got=%h exp=%h", p, vid_data, ed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_back_to_back();
    test_junk();
    test_underflow();
    test_tlast();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
